project_sched: RTL and testbench

//  Sequences the combinational projection datapath (project_cal) once per frame.
//  On frame_start it advances the rotation angles and walks triangle memory one entry at a time.
//  For each triangle it drives the vertices into the datapath and waits SETTLE cycles (multicycle path).
//  It then captures the projected triangle and the clip flag, and hands non-clipped results to the rasterizer over valid/ready.

---
 rtl/project_pkg.sv | 29 ++
 rtl/project_sched_if.sv | 22 ++
 rtl/project_sched_angle_accum.sv | 34 +++
 rtl/project_sched.sv | 130 +++++++++++++
 tb/tb_project_sched.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/project_pkg.sv
// Shared types and constants for the projection scheduler.
// Fixed-point widths, state encoding and triangle bundles.
package project_pkg;

  localparam int WI   = 8;
  localparam int WF   = 8;
  localparam int WIIA = 4;
  localparam int WIFA = 8;
  localparam int WV   = WI + WF;
  localparam int WA   = WIIA + WIFA;

  typedef logic [WA-1:0] angle_t;

  localparam angle_t TWO_PI = 12'h649;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SETTLE,
    S_EMIT,
    S_NEXT,
    S_DONE
  } sched_state_t;

  typedef logic [2:0][2:0][WV-1:0] tri3d_t;
  typedef logic [2:0][1:0][9:0]    tri2d_t;

endpackage

// File: rtl/project_sched_if.sv
// Valid/ready channel carrying projected triangles
// from the scheduler to the rasterizer.
interface project_sched_if;
  import project_pkg::*;

  logic   out_valid;
  logic   out_ready;
  tri2d_t out_triangle;

  modport master (
    output out_valid,
    output out_triangle,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_triangle,
    output out_ready
  );

endinterface

// File: rtl/project_sched_angle_accum.sv
// Per-frame angle accumulator, wrapping modulo TWO_PI.
// Result is always kept in [0, TWO_PI-1].
module angle_accum
  import project_pkg::*;
#(
  parameter angle_t STEP = 12'h010
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   step,
  input  logic   clear,
  output angle_t angle
);

  logic [WA:0] sum;
  angle_t      nxt;

  always_comb begin
    sum = {1'b0, angle} + {1'b0, STEP};
    nxt = sum[WA-1:0];
    if (sum >= {1'b0, TWO_PI}) begin
      nxt = WA'(sum - {1'b0, TWO_PI});
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      angle <= '0;
    end else if (step) begin
      angle <= nxt;
    end
  end

endmodule

// File: rtl/project_sched.sv
// Frame sequencer for the combinational projection datapath:
// walks triangle memory, holds inputs for SETTLE cycles, emits results.
module project_sched
  import project_pkg::*;
#(
  parameter int     AW         = 6,
  parameter int     SETTLE     = 4,
  parameter angle_t ALPHA_STEP = 12'h010,
  parameter angle_t GAMMA_STEP = 12'h008
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [AW:0]      tri_count,
  output logic [AW-1:0]    mem_addr,
  input  tri3d_t           mem_rdata,
  output tri3d_t           orig_triangle,
  output angle_t           alpha,
  output angle_t           beta,
  output angle_t           gamma,
  input  tri2d_t           proj_triangle,
  input  logic             clip,
  project_sched_if.master  out_if,
  output logic             busy,
  output logic             frame_done,
  output logic [AW:0]      drop_count
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  sched_state_t  state;
  sched_state_t  nxt;
  logic [AW:0]   tc_q;
  logic [CW-1:0] cnt;
  logic          clip_q;
  tri2d_t        tri_q;
  logic          accept;
  logic          last;

  assign accept = (state == S_IDLE) && frame_start;
  assign last   = {1'b0, mem_addr} == (tc_q - (AW+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          nxt = (tri_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH:  nxt = S_LOAD;
      S_LOAD:   nxt = S_SETTLE;
      S_SETTLE: if (cnt == '0) nxt = S_EMIT;
      S_EMIT:   if (clip_q || out_if.out_ready) nxt = S_NEXT;
      S_NEXT:   nxt = last ? S_DONE : S_FETCH;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // busy covers the accepting cycle as well as the whole walk
  assign busy       = (state != S_IDLE) || (frame_start && !reset);
  assign frame_done = (state == S_DONE);

  assign out_if.out_valid    = (state == S_EMIT) && !clip_q;
  assign out_if.out_triangle = tri_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tc_q          <= '0;
      drop_count    <= '0;
      mem_addr      <= '0;
      orig_triangle <= '0;
      cnt           <= '0;
      clip_q        <= 1'b0;
      tri_q         <= '0;
    end else begin
      if (accept) begin
        tc_q       <= tri_count;
        drop_count <= '0;
        mem_addr   <= '0;
      end
      if (state == S_LOAD) begin
        orig_triangle <= mem_rdata;
        cnt           <= CW'(SETTLE - 1);
      end
      if (state == S_SETTLE) begin
        if (cnt == '0) begin
          tri_q  <= proj_triangle;
          clip_q <= clip;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
      if (state == S_EMIT && clip_q) begin
        drop_count <= drop_count + (AW+1)'(1);
      end
      if (state == S_NEXT && !last) begin
        mem_addr <= mem_addr + AW'(1);
      end
    end
  end

  angle_accum #(.STEP(ALPHA_STEP)) u_alpha (
    .clk   (clk),
    .reset (reset),
    .step  (accept),
    .clear (1'b0),
    .angle (alpha)
  );

  angle_accum #(.STEP(GAMMA_STEP)) u_gamma (
    .clk   (clk),
    .reset (reset),
    .step  (accept),
    .clear (1'b0),
    .angle (gamma)
  );

  assign beta = '0;

endmodule

// File: tb/tb_project_sched.sv
// Scoreboard bench for project_sched with a stand-in datapath
// and a registered triangle memory.
module tb_project_sched;
  import project_pkg::*;

  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [AW:0] tri_count;
  logic [AW-1:0] mem_addr;
  tri3d_t      mem_rdata;
  tri3d_t      orig_triangle;
  angle_t      alpha, beta, gamma;
  tri2d_t      proj_triangle;
  logic        clip;
  logic        busy, frame_done;
  logic [AW:0] drop_count;

  project_sched_if sif();

  always #5 clk = ~clk;

  project_sched #(.AW(AW), .SETTLE(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .tri_count     (tri_count),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .orig_triangle (orig_triangle),
    .alpha         (alpha),
    .beta          (beta),
    .gamma         (gamma),
    .proj_triangle (proj_triangle),
    .clip          (clip),
    .out_if        (sif),
    .busy          (busy),
    .frame_done    (frame_done),
    .drop_count    (drop_count)
  );

  function automatic tri2d_t proj_f(input tri3d_t t);
    tri2d_t r;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 2; c++)
        r[v][c] = t[v][c][9:0] + t[v][2][9:0];
    return r;
  endfunction

  function automatic tri3d_t mk(input int seed, input bit clp);
    tri3d_t t;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 3; c++)
        t[v][c] = 16'(seed * 37 + v * 11 + c * 3 + 5);
    t[0][2][WV-1] = clp;
    return t;
  endfunction

  function automatic angle_t step_f(input angle_t a, input angle_t s);
    int x;
    x = int'(a) + int'(s);
    if (x >= int'(TWO_PI)) x = x - int'(TWO_PI);
    return angle_t'(x);
  endfunction

  tri3d_t mem [0:63];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  always_comb begin
    proj_triangle = proj_f(orig_triangle);
    clip = orig_triangle[0][2][WV-1];
  end

  typedef struct {
    tri2d_t t;
    int     addr;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     hs_cnt = 0;
  angle_t ea = '0;
  angle_t eg = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sif.out_valid && sif.out_ready) begin
      exp_t e;
      hs_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL hs_unexpected: got addr %0d expected none",
                 mem_addr);
      end else begin
        e = sb.pop_front();
        chk("hs_tri", 64'(sif.out_triangle), 64'(e.t));
        chk("hs_addr", 64'(mem_addr), 64'(e.addr));
      end
    end
  end

  task automatic load(input int n, input int seed, input bit [7:0] cm);
    for (int i = 0; i < n; i++) begin
      mem[i] = mk(seed + i, cm[i]);
      if (!cm[i]) sb.push_back('{proj_f(mem[i]), i});
    end
  endtask

  task automatic pulse();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    ea = step_f(ea, 12'h010);
    eg = step_f(eg, 12'h008);
  endtask

  task automatic wait_done(input string nm, input int exp_cyc);
    int cyc;
    cyc = 0;
    do begin
      cyc++;
      @(negedge clk);
    end while (!frame_done && cyc < 3000);
    chk(nm, 64'(cyc), 64'(exp_cyc));
  endtask

  int hs0;
  int n;
  int seen;
  tri2d_t et;

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    tri_count = '0;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(sif.out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(frame_done), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_alpha", 64'(alpha), 0);
    chk("rst_gamma", 64'(gamma), 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_orig", 64'(|orig_triangle), 0);

    // three clean triangles
    load(3, 1, 8'h00);
    tri_count = 3;
    hs0 = hs_cnt;
    pulse();
    wait_done("t1_done_cycle", 25);
    chk("t1_busy_in_done", 64'(busy), 1);
    chk("t1_drop", 64'(drop_count), 0);
    chk("t1_alpha", 64'(alpha), 64'(ea));
    chk("t1_gamma", 64'(gamma), 64'(eg));
    chk("t1_beta", 64'(beta), 0);
    chk("t1_hs", 64'(hs_cnt - hs0), 3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_busy_after", 64'(busy), 0);
    chk("t1_done_pulse", 64'(frame_done), 0);
    chk("t1_sb_empty", 64'(sb.size()), 0);

    // clips on entries 1 and 3
    load(4, 20, 8'b0000_1010);
    tri_count = 4;
    hs0 = hs_cnt;
    pulse();
    wait_done("t2_done_cycle", 33);
    chk("t2_drop", 64'(drop_count), 2);
    chk("t2_hs", 64'(hs_cnt - hs0), 2);
    chk("t2_sb_empty", 64'(sb.size()), 0);

    // backpressure in EMIT
    load(1, 40, 8'h00);
    et = proj_f(mem[0]);
    tri_count = 1;
    sif.out_ready = 1'b0;
    hs0 = hs_cnt;
    pulse();
    n = 0;
    do begin
      n++;
      @(negedge clk);
    end while (!sif.out_valid && n < 100);
    chk("t3_valid_cycle", 64'(n), 7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_valid_held", 64'(sif.out_valid), 1);
      chk("t3_tri_held", 64'(sif.out_triangle), 64'(et));
      chk("t3_addr_held", 64'(mem_addr), 0);
    end
    @(posedge clk); #1 sif.out_ready = 1'b1;
    wait_done("t3_done_cycle", 3);
    chk("t3_hs", 64'(hs_cnt - hs0), 1);
    chk("t3_alpha", 64'(alpha), 64'(ea));

    // empty frame
    tri_count = 0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(negedge clk);
    chk("t4_busy_accept", 64'(busy), 1);
    @(posedge clk); #1 frame_start = 1'b0;
    ea = step_f(ea, 12'h010);
    eg = step_f(eg, 12'h008);
    @(negedge clk);
    chk("t4_busy_done", 64'(busy), 1);
    chk("t4_done", 64'(frame_done), 1);
    chk("t4_valid", 64'(sif.out_valid), 0);
    chk("t4_addr", 64'(mem_addr), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_busy_after", 64'(busy), 0);
    chk("t4_done_after", 64'(frame_done), 0);
    chk("t4_alpha", 64'(alpha), 64'(ea));

    // frame_start while busy is ignored
    load(2, 60, 8'h00);
    tri_count = 2;
    hs0 = hs_cnt;
    pulse();
    repeat (4) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_done("t5_done_cycle", 12);
    chk("t5_alpha", 64'(alpha), 64'(ea));
    chk("t5_gamma", 64'(gamma), 64'(eg));
    chk("t5_hs", 64'(hs_cnt - hs0), 2);
    repeat (3) @(negedge clk);
    chk("t5_idle", 64'(busy), 0);

    // reset during SETTLE of the second triangle
    mem[0] = mk(80, 1'b0);
    mem[1] = mk(81, 1'b0);
    sb.push_back('{proj_f(mem[0]), 0});
    tri_count = 2;
    pulse();
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    ea = '0;
    eg = '0;
    @(negedge clk);
    chk("t6_valid", 64'(sif.out_valid), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_addr", 64'(mem_addr), 0);
    chk("t6_tri", 64'(sif.out_triangle), 0);
    chk("t6_alpha", 64'(alpha), 0);
    chk("t6_gamma", 64'(gamma), 0);
    chk("t6_drop", 64'(drop_count), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_done || sif.out_valid) seen++;
    end
    chk("t6_quiet", 64'(seen), 0);
    chk("t6_sb_empty", 64'(sb.size()), 0);

    // angle wrap
    tri_count = 0;
    repeat (100) begin
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      ea = step_f(ea, 12'h010);
      eg = step_f(eg, 12'h008);
      @(posedge clk);
    end
    @(negedge clk);
    chk("t7_alpha_640", 64'(alpha), 64'h640);
    chk("t7_gamma_320", 64'(gamma), 64'h320);
    chk("t7_alpha_model", 64'(alpha), 64'(ea));
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    chk("t7_alpha_wrap", 64'(alpha), 64'h007);
    chk("t7_gamma_step", 64'(gamma), 64'h328);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
